cpu_muldiv: RTL and testbench
=============================

CPU_MULDIV -- requirements
Module: cpu_muldiv

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 SHALL be supported.
REQ-002 Port clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port start  input  1  request; SHALL be sampled only in IDLE.
REQ-005 Port funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 Port a  input  32  rs1 operand (register-file rd1).
REQ-007 Port b  input  32  rs2 operand (register-file rd2).
REQ-008 Port rd_in  input  5  destination register tag.
REQ-009 Port busy  output  1  high in CALC and DONE.
REQ-010 Port valid  output  1  one-cycle result strobe, intended to drive register-file we3.
REQ-011 Port result  output  32  result, intended for wd3.
REQ-012 Port rd_out  output  5  latched rd_in, intended for a3.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE.
REQ-014 IDLE with start=1 at edge E SHALL latch a, b, funct3 and rd_in, clear the iteration counter, and enter CALC.
REQ-015 Operand or funct3 changes after E SHALL NOT affect the operation.
REQ-016 CALC SHALL perform one iteration per cycle: shift-add for multiply (64-bit product of magnitudes), restoring division for divide (magnitudes).
REQ-017 After the 32nd iteration (edge E+32) the FSM SHALL enter DONE and register result with sign correction applied.
REQ-018 valid SHALL be high for exactly the cycle after E+32; start-to-valid latency SHALL be 32 cycles for all ops.
REQ-019 DONE SHALL return to IDLE at the next edge; back-to-back issue interval SHALL be 34 cycles.
REQ-020 start while busy=1 SHALL be ignored, with no queuing.
REQ-021 MUL SHALL return product[31:0]; MULH product[63:32] signed x signed; MULHSU signed a x unsigned b; MULHU unsigned x unsigned.
REQ-022 DIV/REM SHALL truncate toward zero; remainder sign SHALL equal the dividend sign.
REQ-023 Divide by zero SHALL return quotient 0xFFFFFFFF and remainder = a, with the normal latency.
REQ-024 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL return quotient 0x80000000 and remainder 0, with the normal latency.
REQ-025 result and rd_out SHALL hold their value until the next DONE; rd_out=0 SHALL still produce valid (the register file discards x0).

Reset
REQ-026 rst=1 SHALL force IDLE and busy=0, valid=0, result=0, rd_out=0 at the next edge.
REQ-027 rst mid-operation SHALL abort without producing valid.
REQ-028 start sampled in the same cycle as rst SHALL be ignored.

Configuration
REQ-029 Macro CPU_MULDIV_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU SHALL compute combinationally at start and go IDLE->DONE, giving valid in the cycle after E (latency 1).
REQ-030 With CPU_MULDIV_FAST_MUL_EN, divide ops SHALL be unchanged.
REQ-031 Macro undefined: every op SHALL use the iterative 32-cycle path.

Verification
REQ-032 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB; valid exactly 32 cycles after start; rd_out = rd_in.
REQ-033 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-035 DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of same -> 0.
REQ-036 start pulsed at cycle 5 of an op -> ignored, first result unchanged; rst at cycle 10 of an op -> busy=0 next cycle, no valid, next start completes normally.
REQ-037 With CPU_MULDIV_FAST_MUL_EN: MUL 6x7 -> 42 with valid 1 cycle after start; DIVU 42/6 -> 7 with valid 32 cycles after start.

Source files
------------

// File: rtl/cpu_muldiv.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply, restoring divide.
// Define CPU_MULDIV_FAST_MUL_EN to compute multiplies in one cycle; divides stay iterative.
module cpu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic [XLEN-1:0]   a_q, a_d, result_q, result_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d, neg_rem_q, neg_rem_d, b_zero_q, b_zero_d;
    logic [4:0]        rd_lat_q, rd_lat_d, rd_out_q, rd_out_d;

    logic              signed_a, signed_b, sign_a, sign_b;
    logic [XLEN-1:0]   in_mag_a, in_mag_b;

    always_comb begin
        signed_a = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
        signed_b = funct3 inside {3'b000, 3'b001, 3'b100, 3'b110};
        sign_a   = signed_a & a[XLEN-1];
        sign_b   = signed_b & b[XLEN-1];
        in_mag_a = sign_a ? -a : a;
        in_mag_b = sign_b ? -b : b;
    end

    logic [XLEN:0]     mul_sum, div_sh;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] iter, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

    // acc holds {partial product, remaining multiplier} or {partial remainder, dividend/quotient}
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
        div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge   = div_sh >= {1'b0, mag_b_q};
        div_diff = div_sh[XLEN-1:0] - mag_b_q;
        if (op_q[2]) begin
            iter = {(div_ge ? div_diff : div_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
        end else begin
            iter = {mul_sum, acc_q[XLEN-1:1]};
        end
        prod_fix = neg_q ? -iter : iter;
        quo_fix  = neg_q ? -iter[XLEN-1:0] : iter[XLEN-1:0];
        rem_fix  = neg_rem_q ? -iter[2*XLEN-1:XLEN] : iter[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 final_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = b_zero_q ? '1 : quo_fix;
            default:                final_res = b_zero_q ? a_q : rem_fix;
        endcase
    end

`ifdef CPU_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]   fast_res;

    // Sign-extended 2*XLEN operands give the correct product modulo 2^(2*XLEN)
    always_comb begin
        fast_prod = {{XLEN{sign_a}}, a} * {{XLEN{sign_b}}, b};
        fast_res  = (funct3 == 3'b000) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        a_d       = a_q;
        op_d      = op_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        b_zero_d  = b_zero_q;
        rd_lat_d  = rd_lat_q;
        rd_out_d  = rd_out_q;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d      = funct3;
                    a_d       = a;
                    mag_a_d   = in_mag_a;
                    mag_b_d   = in_mag_b;
                    neg_d     = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    b_zero_d  = (b == '0);
                    rd_lat_d  = rd_in;
                    cnt_d     = '0;
                    acc_d     = funct3[2] ? {{XLEN{1'b0}}, in_mag_a} : {{XLEN{1'b0}}, in_mag_b};
                    state_d   = CALC;
`ifdef CPU_MULDIV_FAST_MUL_EN
                    if (!funct3[2]) begin
                        result_d = fast_res;
                        rd_out_d = rd_in;
                        state_d  = DONE;
                    end
`endif
                end
            end
            CALC: begin
                acc_d = iter;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(XLEN - 1)) begin
                    result_d = final_res;
                    rd_out_d = rd_lat_q;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            a_q       <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
            rd_lat_q  <= '0;
            rd_out_q  <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            a_q       <= a_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            b_zero_q  <= b_zero_d;
            rd_lat_q  <= rd_lat_d;
            rd_out_q  <= rd_out_d;
            result_q  <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign valid  = (state_q == DONE);
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_cpu_muldiv.sv
// Self-checking bench for cpu_muldiv: directed RV32M corner cases, random ops vs. arithmetic model,
// busy/abort behaviour and issue interval.
module tb_cpu_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        valid;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_checks = 0;
    int n_errors = 0;

    cpu_muldiv #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .rd_in  (rd_in),
        .busy   (busy),
        .valid  (valid),
        .result (result),
        .rd_out (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // RV32M semantics from plain arithmetic
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xs, ys, p;
        logic        ovf;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (f3)
            3'd0: return x * y;
            3'd1: begin xs = {{32{x[31]}}, x}; ys = {{32{y[31]}}, y}; p = xs * ys; return p[63:32]; end
            3'd2: begin xs = {{32{x[31]}}, x}; ys = {32'd0, y};       p = xs * ys; return p[63:32]; end
            3'd3: begin xs = {32'd0, x};       ys = {32'd0, y};       p = xs * ys; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                return $signed(x) / $signed(y);
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (ovf)    return 32'd0;
                return $signed(x) % $signed(y);
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3);
`ifdef CPU_MULDIV_FAST_MUL_EN
        if (!f3[2]) return 1;
`endif
        return 32;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] av,
                          input logic [31:0] bv, input logic [4:0] rd, input int poke);
        int n;
        logic [31:0] exp_res;
        exp_res = model(f3, av, bv);
        @(negedge clk);
        funct3 = f3; a = av; b = bv; rd_in = rd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        funct3 = 3'($urandom); a = $urandom; b = $urandom; rd_in = 5'($urandom);
        chk({tag, "_busy"}, busy, 1);
        n = 0;
        while (1) begin
            @(posedge clk); #1;
            n++;
            start = (n == poke);
            if (start) begin
                funct3 = 3'($urandom); a = $urandom; b = $urandom; rd_in = 5'($urandom);
            end
            if (valid || n >= 100) break;
        end
        start = 1'b0;
        chk({tag, "_lat"}, n, exp_lat(f3));
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_rd"}, rd_out, rd);
        @(posedge clk); #1;
        chk({tag, "_vld_off"}, valid, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_hold"}, result, exp_res);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [6];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
        if ($urandom_range(0, 9) < 3) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        int t, v1, v2, nv;
        rst = 1'b1; start = 1'b1; funct3 = 3'd5; a = 32'd100; b = 32'd7; rd_in = 5'd9;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_result", result, 0);
        chk("rst_rd", rd_out, 0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("rst_start_ignored", busy, 0);

        run_op("mul_neg",  3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  0);
        run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6,  0);
        run_op("mulhu",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  0);
        run_op("mulhsu",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  0);
        run_op("div_neg",  3'd4, 32'hFFFF_FFF9, 32'd2,         5'd10, 0);
        run_op("rem_neg",  3'd6, 32'hFFFF_FFF9, 32'd2,         5'd11, 0);
        run_op("divu",     3'd5, 32'd100,       32'd7,         5'd12, 0);
        run_op("remu",     3'd7, 32'd100,       32'd7,         5'd0,  0);
        run_op("div_z",    3'd4, 32'd5,         32'd0,         5'd13, 0);
        run_op("rem_z",    3'd6, 32'd5,         32'd0,         5'd14, 0);
        run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 0);
        run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 0);
        run_op("mul_6x7",  3'd0, 32'd6,         32'd7,         5'd17, 0);
        run_op("divu_42",  3'd5, 32'd42,        32'd6,         5'd18, 0);

        run_op("poke_busy", 3'd5, 32'd1000, 32'd9, 5'd19, 5);
        repeat (3) begin
            @(posedge clk); #1;
            chk("poke_no_queue", busy, 0);
        end

        @(negedge clk);
        funct3 = 3'd4; a = 32'hFFFF_0000; b = 32'd3; rd_in = 5'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", valid, 0);
        chk("abort_result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        nv = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid) nv++;
        end
        chk("abort_no_valid", nv, 0);
        run_op("after_abort", 3'd6, 32'hFFFF_0000, 32'd3, 5'd21, 0);

        @(negedge clk);
        funct3 = 3'd5; a = 32'd1000; b = 32'd9; rd_in = 5'd3; start = 1'b1;
        t = 0; v1 = -1; v2 = -1;
        while (v2 < 0 && t < 120) begin
            @(posedge clk); #1;
            t++;
            if (valid) begin
                if (v1 < 0) v1 = t;
                else        v2 = t;
            end
        end
        start = 1'b0;
        chk("b2b_gap", v2 - v1, 34);
        chk("b2b_res", result, 32'd111);
        @(posedge clk); #1;

        for (int i = 0; i < 60; i++) begin
            run_op("rand", 3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
